// File: rtl/seg_scan_capture_if.sv
// Display-bus bundle between a 7-segment scanner (master) and the capture monitor (slave).
interface seg_scan_capture_if;
    logic [3:0]  anode;
    logic [6:0]  eSeg;
    logic [15:0] num;
    logic        frame_valid;
    logic [3:0]  digit_err;
    logic        anode_err;
    logic        stale;

    modport master (
        output anode, eSeg,
        input  num, frame_valid, digit_err, anode_err, stale
    );

    modport slave (
        input  anode, eSeg,
        output num, frame_valid, digit_err, anode_err, stale
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Loop-back reader for the multiplexed 4-digit 7-segment bus: filters, decodes and frames digits.
// Optional frame timeout / stale flag is built when SEG_CAPTURE_TIMEOUT_EN is defined.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 262144
) (
    input logic clk_osc,
    input logic reset,
    seg_scan_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] COMMIT  = 1'b1;

    logic [3:0]    s_anode, p_anode;
    logic [6:0]    s_seg, p_seg;
    logic [CW-1:0] cnt, cnt_next;
    logic          armed;
    logic          changed, accept;
    logic [0:0]    state;
    logic [3:0]    seen, seen_next;
    logic [3:0]    sel;
    logic          illegal;
    logic [3:0]    dec_val;
    logic          dec_err;
    logic [15:0]   stage_num, num_r;
    logic [3:0]    stage_err, err_r;
    logic          fv_r, aerr_r;
    logic          tmo_hit;
    logic          commit;

    assign commit = (state == COMMIT);

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            s_anode <= 4'hF;
            s_seg   <= 7'h00;
            p_anode <= 4'hF;
            p_seg   <= 7'h00;
        end else begin
            s_anode <= bus.anode;
            s_seg   <= bus.eSeg;
            p_anode <= s_anode;
            p_seg   <= s_seg;
        end
    end

    // One acceptance per dwell: armed drops on acceptance and only returns when the pair changes.
    always_comb begin
        changed = ({s_anode, s_seg} != {p_anode, p_seg});
        if (changed)
            cnt_next = '0;
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + 1'b1;
        accept = !changed && armed && (cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            cnt <= cnt_next;
            if (changed)
                armed <= 1'b1;
            else if (accept)
                armed <= 1'b0;
        end
    end

    always_comb begin
        sel     = 4'b0000;
        illegal = 1'b0;
        case (s_anode)
            4'b1110: sel = 4'b0001;
            4'b1101: sel = 4'b0010;
            4'b1011: sel = 4'b0100;
            4'b0111: sel = 4'b1000;
            4'b1111: sel = 4'b0000;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_err = 1'b0;
        case (s_seg)
            7'b0111111: dec_val = 4'd0;
            7'b0000110: dec_val = 4'd1;
            7'b1011011: dec_val = 4'd2;
            7'b1001111: dec_val = 4'd3;
            7'b1100110: dec_val = 4'd4;
            7'b1101101: dec_val = 4'd5;
            7'b1111101: dec_val = 4'd6;
            7'b0000111: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1101111: dec_val = 4'd9;
            7'b0000000: dec_val = 4'hF;
            default: begin
                dec_val = 4'hE;
                dec_err = 1'b1;
            end
        endcase
    end

    // Clears (commit or timeout) apply before the accepted digit's bit is merged in.
    always_comb begin
        seen_next = (commit || tmo_hit) ? 4'b0000 : seen;
        if (accept)
            seen_next = seen_next | sel;
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            state     <= COLLECT;
            seen      <= 4'b0000;
            stage_num <= 16'h0000;
            stage_err <= 4'b0000;
        end else begin
            seen <= seen_next;
            if (state == COLLECT) begin
                if (seen_next == 4'b1111)
                    state <= COMMIT;
            end else begin
                state <= COLLECT;
            end
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        stage_num[4*i +: 4] <= dec_val;
                        stage_err[i]        <= dec_err;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            num_r  <= 16'h0000;
            err_r  <= 4'b0000;
            fv_r   <= 1'b0;
            aerr_r <= 1'b0;
        end else begin
            fv_r   <= commit;
            aerr_r <= accept && illegal;
            if (commit) begin
                num_r <= stage_num;
                err_r <= stage_err;
            end
        end
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(FRAME_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(FRAME_TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          stale_r;

    assign tmo_hit = !commit && (tmo_cnt == TMO_MAX - 1'b1);

    // Counter parks at its maximum so the seen-clear fires only once per timeout.
    always_ff @(posedge clk_osc) begin
        if (reset) begin
            tmo_cnt <= '0;
            stale_r <= 1'b0;
        end else if (commit) begin
            tmo_cnt <= '0;
            stale_r <= 1'b0;
        end else begin
            if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                stale_r <= 1'b1;
        end
    end

    assign bus.stale = stale_r;
`else
    assign tmo_hit   = 1'b0;
    assign bus.stale = 1'b0;
`endif

    assign bus.num         = num_r;
    assign bus.digit_err   = err_r;
    assign bus.frame_valid = fv_r;
    assign bus.anode_err   = aerr_r;
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side monitor for the multiplexed 4-digit 7-segment display bus. Samples the active-low one-hot `anode` strobe and the `eSeg` segment pattern driven by the display scanner, filters scan transitions, decodes each digit's pattern back to its BCD value, and publishes a coherent 16-bit frame once all four digit positions have been captured. Sits beside the display driver on `clk_osc`, and serves as a self-check and loop-back reader for the time, alarm and stopwatch displays.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical `{anode,eSeg}` samples required before a digit is accepted; legal range is 2 or more.
- `FRAME_TIMEOUT`, default 262144: count of `clk_osc` cycles without a frame commit before `stale` asserts. Used only with the timeout feature.

Ports:
- `clk_osc` input 1: single clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `anode` input 4: digit strobe, active-low one-hot. Bit 0 is the rightmost digit and bit 3 is the leftmost.
- `eSeg` input 7: segment pattern, active-high, bit 6 = g down to bit 0 = a.
- `num` output 16: last committed frame, one BCD nibble per digit. Nibble `[3:0]` is the rightmost digit.
- `frame_valid` output 1: one-cycle pulse when `num` updates.
- `digit_err` output 4: per-digit flag, captured at commit. A bit is 1 when that digit's pattern was undecodable.
- `anode_err` output 1: one-cycle pulse for a stable, illegal strobe.
- `stale` output 1: level, frame timeout. Present only with the timeout feature; otherwise tied to 0.

## Operation
- **Input stage.** `anode` and `eSeg` are registered once before use, giving `s_anode` and `s_seg`.
- **Stability counter `cnt`.**
  - Clears to 0 when `{s_anode,s_seg}` differs from its previous registered value.
  - Otherwise increments and saturates at `STABLE_CYCLES-1`.
  - An `armed` flag allows exactly one acceptance per dwell. It re-arms when `cnt` clears.
- **Acceptance.** Occurs when `cnt` reaches `STABLE_CYCLES-1` while `armed` is set.
  - `s_anode` with exactly one 0 bit: the digit at that position is decoded into the staging register, its err bit is written, and its `seen` mask bit is set.
  - `s_anode` = 4'b1111 (blanking interval): ignored silently.
  - `s_anode` with two or more 0 bits: `anode_err` pulses and nothing is staged.
- **Decode.** Active-high patterns map as follows:
  - 0111111 → 0
  - 0000110 → 1
  - 1011011 → 2
  - 1001111 → 3
  - 1100110 → 4
  - 1101101 → 5
  - 1111101 → 6
  - 0000111 → 7
  - 1111111 → 8
  - 1101111 → 9
  - 0000000 → 4'hF (blank, no error)
  - any other pattern → 4'hE with the err bit set
- **Re-capture before commit.** If a digit position is accepted again before the frame commits, its staged nibble and err bit are overwritten.
- **Commit FSM.**
  - States are `COLLECT` and `COMMIT`.
  - `COLLECT` → `COMMIT` when `seen` becomes 4'b1111 (including the case where the completing acceptance happens in that cycle).
  - In `COMMIT`: `num` and `digit_err` load from staging, `frame_valid` = 1, `seen` clears, and the FSM returns to `COLLECT` unconditionally on the next edge.
  - An acceptance that arrives during `COMMIT` belongs to the next frame.

## Timing
- **Reset values.** On any edge with `reset`=1, all of the following clear:
  - `num`=16'h0000, `frame_valid`=0, `digit_err`=4'b0000, `anode_err`=0, `stale`=0
  - `seen`=0, `cnt`=0, `armed`=1, FSM=`COLLECT`, timeout counter=0
  - Reset asserted mid-frame discards partially staged digits.
- **Acceptance latency.** A pair first present at the inputs in cycle 0 and held constant is accepted on the edge ending cycle `STABLE_CYCLES`. This is 1 cycle of input registering plus `STABLE_CYCLES-1` cycles of counting.
- **Commit latency.** If that acceptance completes `seen`, `frame_valid` and the new `num` are visible 1 cycle later.
- **Dwell filter.** A dwell shorter than `STABLE_CYCLES` cycles is never accepted.
- **Pulse widths.** `anode_err` and `frame_valid` are exactly one cycle wide. `num` holds its value between commits.

## Configuration
- Macro: `SEG_CAPTURE_TIMEOUT_EN`.
- **Defined.**
  - A counter of width ≥ clog2(`FRAME_TIMEOUT`) increments every cycle in which no commit occurs, and clears on commit.
  - When it reaches `FRAME_TIMEOUT-1`, `stale` sets to 1 and `seen` clears. The counter then holds.
  - `stale` clears in the `COMMIT` cycle.
  - If a timeout and an acceptance occur in the same cycle, the clear applies first, then the accepted digit's `seen` bit is set.
- **Undefined.** No counter is built, `stale` is constant 0, and `seen` clears only on commit or reset.

## Test plan
- Scan `anode` 1110/1101/1011/0111 with patterns for 1,2,3,4, dwell 8 cycles each → single `frame_valid` pulse, `num`=16'h4321, `digit_err`=0000.
- Same scan with a 3-cycle glitch pattern 1111111 inserted at the start of each dwell, `STABLE_CYCLES`=4 → glitch is not captured, `num`=16'h4321.
- Digit 2 pattern 1010101, the others 0 → `num`=16'h0E00, `digit_err`=0100.
- Hold `anode`=1100 for 10 cycles → exactly one `anode_err` pulse, `seen` unchanged, no `frame_valid`.
- With `SEG_CAPTURE_TIMEOUT_EN` and `FRAME_TIMEOUT`=64: capture 3 digits, then hold `anode`=1111 → `stale`=1 at cycle 63 after the last commit; a full scan afterwards gives `frame_valid` and `stale`=0.
- Assert `reset` after 2 digits are captured, then complete the remaining 2 digits → no commit; a full 4-digit scan afterwards is required.
